// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared select encodings and pipeline-record type for the EX operand
// forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam logic [2:0] SEL_RF    = 3'b000;
  localparam logic [2:0] SEL_EXMEM = 3'b001;
  localparam logic [2:0] SEL_MEMWB = 3'b010;
  localparam logic [2:0] SEL_IMM   = 3'b011;
  localparam logic [2:0] SEL_HILO  = 3'b100;

  localparam int REC_AW = 5;

  typedef struct packed {
    logic              we;
    logic [REC_AW-1:0] wreg;
    logic              load;
  } pipe_rec_t;

  localparam pipe_rec_t REC_BUBBLE = '{we: 1'b0, wreg: '0, load: 1'b0};

endpackage

// File: rtl/fwd_hazard_ctrl_muldiv_timer.sv
// Countdown for an in-flight mul/div: loads on launch, counts to zero,
// busy while non-zero. Reset abandons the operation immediately.
module muldiv_timer #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam logic [3:0] LOAD_VAL = 4'(MULDIV_CYCLES);

  logic [3:0] cnt_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (load) begin
      cnt_p1 <= LOAD_VAL;
    end else if (cnt_p1 != '0) begin
      cnt_p1 <= cnt_p1 - 4'd1;
    end
  end

  // Combinational so the 1->0 step releases a waiting HI/LO reader at once.
  assign busy = (cnt_p1 != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand A/B select generation with load-use and mul/div stalls.
// Tracks the destination of the instructions currently in EX and MEM.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_imm_b,
  input  logic              id_hilo_rd,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_muldiv,
  input  logic              flush,
  output logic [2:0]        ex_sel_a,
  output logic [2:0]        ex_sel_b,
  output logic              stall,
  output logic              muldiv_busy
);

  pipe_rec_t         ex_rec_p1;
  logic              mem_we_p2;
  logic [REC_AW-1:0] mem_wreg_p2;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use, muldiv_hold, accept;
  logic [2:0] sel_a_p0, sel_b_p0;

  // Register 0 is hard-wired, so a write to it never counts as a producer.
  function automatic logic src_match(input logic use_src, input logic rec_we,
                                     input logic [REC_AW-1:0] rec_wreg,
                                     input logic [REG_AW-1:0] src);
    return use_src && rec_we && (rec_wreg == REC_AW'(src)) && (src != '0);
  endfunction

  function automatic logic [2:0] pick_sel(input logic take, input logic ovr,
                                          input logic [2:0] ovr_sel,
                                          input logic ex_hit, input logic mem_hit);
    if (!take)   return SEL_RF;
    if (ovr)     return ovr_sel;
    if (ex_hit)  return SEL_EXMEM;
    if (mem_hit) return SEL_MEMWB;
    return SEL_RF;
  endfunction

  // Stage p0: hazard detection and select decode for the ID instruction
  assign ex_hit_a  = src_match(id_use_rs, ex_rec_p1.we, ex_rec_p1.wreg, id_rs);
  assign ex_hit_b  = src_match(id_use_rt, ex_rec_p1.we, ex_rec_p1.wreg, id_rt);
  assign mem_hit_a = src_match(id_use_rs, mem_we_p2, mem_wreg_p2, id_rs);
  assign mem_hit_b = src_match(id_use_rt, mem_we_p2, mem_wreg_p2, id_rt);

  assign load_use    = id_valid && ex_rec_p1.load && (ex_hit_a || ex_hit_b);
  assign muldiv_hold = id_valid && (id_hilo_rd || id_muldiv) && muldiv_busy;
  assign stall       = !flush && (load_use || muldiv_hold);
  assign accept      = id_valid && !stall && !flush;

  assign sel_a_p0 = pick_sel(accept, id_hilo_rd, SEL_HILO, ex_hit_a, mem_hit_a);
  assign sel_b_p0 = pick_sel(accept, id_imm_b, SEL_IMM, ex_hit_b, mem_hit_b);

  // Stage p1/p2: EX and MEM destination records, registered selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rec_p1   <= REC_BUBBLE;
      mem_we_p2   <= 1'b0;
      mem_wreg_p2 <= '0;
      ex_sel_a    <= SEL_RF;
      ex_sel_b    <= SEL_RF;
    end else begin
      mem_we_p2   <= ex_rec_p1.we;
      mem_wreg_p2 <= ex_rec_p1.wreg;
      if (accept) begin
        ex_rec_p1 <= '{we: id_we, wreg: REC_AW'(id_wreg), load: id_load};
      end else begin
        ex_rec_p1 <= REC_BUBBLE;
      end
      ex_sel_a <= sel_a_p0;
      ex_sel_b <= sel_b_p0;
    end
  end

  muldiv_timer #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_timer (
    .clk (clk),
    .rst (rst),
    .load(accept && id_muldiv),
    .busy(muldiv_busy)
  );

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Operand-select and hazard controller for the EX-stage 5-input 32-bit operand muxes, operand A and operand B.
- Tracks in-flight destination registers of the EX and MEM stages and produces registered 3-bit selects for the instruction entering EX.
- Generates the pipeline stall for load-use hazards and for an outstanding multi-cycle mul/div unit.

Parameters:
- REG_AW, 5, register-index width.
- MULDIV_CYCLES, 4, cycles from mul/div launch until HI/LO valid (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A index.
- id_rt  in  REG_AW  source register B index.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_imm_b  in  1  operand B is the immediate.
- id_hilo_rd  in  1  operand A is HI/LO (mfhi/mflo).
- id_wreg  in  REG_AW  destination register.
- id_we  in  1  instruction writes the register file.
- id_load  in  1  instruction is a load.
- id_muldiv  in  1  instruction launches mul/div.
- flush  in  1  squash the ID instruction (taken branch/jump).
- ex_sel_a  out  3  operand A mux select, registered.
- ex_sel_b  out  3  operand B mux select, registered.
- stall  out  1  hold PC and IF/ID; insert bubble into EX. Combinational.
- muldiv_busy  out  1  mul/div counter non-zero.

Behaviour:
- Select encoding:
  - 000 register file
  - 001 EX/MEM ALU result
  - 010 MEM/WB result
  - 011 immediate
  - 100 HI/LO
  - 101..111 never driven.
- State:
  - EX record {we, wreg, load} and MEM record {we, wreg}.
  - Each rising edge: MEM <= EX; EX <= ID fields, or a bubble (we=0, load=0) when stall, flush or !id_valid.
- Reset (async): both records cleared (we=0), ex_sel_a=ex_sel_b=000, mul/div counter=0, muldiv_busy=0. stall is 0 while records are clear and the counter is 0.
- Match rule:
  - A source matches a record when use=1, record we=1, wreg==src and src!=0.
  - Register 0 is never forwarded.
- Select computed from ID, registered into ex_sel_* on the edge the instruction enters EX:
  - A: id_hilo_rd -> 100; else EX-record match -> 001; else MEM-record match -> 010; else 000.
  - B: id_imm_b -> 011; else EX-record match -> 001; else MEM-record match -> 010; else 000.
  - The newer EX record wins over the MEM record.
  - The register file is write-before-read, so WB-stage producers need no forwarding.
- Load-use stall:
  - stall=1 when id_valid, the EX record has load=1, and rs or rt matches it.
  - Exactly one stall cycle. Next cycle the load is in MEM and the consumer proceeds with select 010.
- Mul/div:
  - On an accepted id_muldiv (not stalled, not flushed), the counter loads MULDIV_CYCLES.
  - The counter decrements each cycle while non-zero. muldiv_busy = (counter!=0).
  - stall=1 when id_valid and (id_hilo_rd or id_muldiv) while muldiv_busy.
  - The count-1 to 0 transition releases stall in the same cycle it reaches 0.
- Bubble and flush outputs:
  - During stall or flush, ex_sel_a/ex_sel_b register 000.
  - flush masks stall (stall=0 when flush=1). The counter does not load for a flushed mul/div.
- Simultaneous events: load-use and mul/div busy together give a single stall. It releases only when both conditions clear.
- Reset mid-operation: the counter is abandoned and muldiv_busy drops immediately.

Decomposition:
- Shared package:
  - Select constants SEL_RF, SEL_EXMEM, SEL_MEMWB, SEL_IMM, SEL_HILO (3-bit).
  - Pipeline record typedef {we, wreg, load}.
- One sub-module, muldiv_timer: load, decrement, busy, with the async reset.

Test Plan:
- add r3 <- r1,r2 then sub r4 <- r3,r5 back-to-back -> ex_sel_a=001, ex_sel_b=000, stall never 1.
- add r3 then nop then or r6 <- r7,r3 -> ex_sel_b=010. Repeat with wreg=r0 -> ex_sel_b=000.
- lw r8 then add r9 <- r8,r8 -> stall=1 for exactly one cycle, bubble selects 000, then ex_sel_a=ex_sel_b=010.
- mult then mfhi on the next cycle with MULDIV_CYCLES=4 -> stall high until the counter reaches 0, then ex_sel_a=100 and muldiv_busy=0.
- lw-use stall with flush=1 in the same cycle -> stall=0, EX record is a bubble, selects 000. Flushed mult -> muldiv_busy stays 0.
- Assert rst while counter=2 and a record is valid -> all outputs 000/0 asynchronously. First post-reset add shows no forwarding.
